// File: rtl/reg4_piso_tx.sv
// rtl/reg4_piso_tx.sv - parallel-in serial-out transmitter, MSB first, ready/valid load
// Optional even-parity trailer bit enabled by defining REG4_TX_PARITY_EN.
module reg4_piso_tx #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef REG4_TX_PARITY_EN
    SHIFT  = 2'd1,
    PARITY = 2'd2
`else
    SHIFT  = 2'd1
`endif
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
`ifdef REG4_TX_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef REG4_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Acceptance ignores ce; only bit advance is qualified by it.
          if (din_valid) begin
            sreg  <= din;
            cnt   <= CW'(WIDTH - 1);
`ifdef REG4_TX_PARITY_EN
            par   <= ^din;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ce) begin
            if (cnt != '0) begin
              sreg <= {sreg[WIDTH-2:0], 1'b0};
              cnt  <= cnt - CW'(1);
            end else begin
`ifdef REG4_TX_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef REG4_TX_PARITY_EN
        PARITY: begin
          if (ce) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    din_ready  = (state == IDLE);
    busy       = (state != IDLE);
    sout_valid = (state != IDLE);
    sout       = IDLE_LEVEL;
    if (state == SHIFT) sout = sreg[WIDTH-1];
`ifdef REG4_TX_PARITY_EN
    if (state == PARITY) sout = par;
`endif
  end

endmodule

// File: tb/tb_reg4_piso_tx.sv
// tb/tb_reg4_piso_tx.sv - scoreboard bench for reg4_piso_tx
// Honors REG4_TX_PARITY_EN to expect the parity trailer bit.
module tb_reg4_piso_tx;

`ifdef REG4_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, sout, sout_valid, busy, done;

  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   words_exp = 0;
  logic exp_q[$];

  reg4_piso_tx #(.WIDTH(4), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef REG4_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
    words_exp++;
  endtask

  // A bit is consumed whenever it is on the line and the next edge advances it.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_seen++;
      if (sout_valid && ce) begin
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check("sout", int'(sout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] w);
    int n = 0;
    din = w;
    din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", int'(n < 50), 1);
    push_word(w);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("rst_ready", int'(din_ready), 1);
    check("rst_valid", int'(sout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sout", int'(sout), 1);
    check("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic timing: bits on cycles 1..NB, done and ready on the next.
    send(4'b1011);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("t_valid", int'(sout_valid), 1);
      check("t_nodone", int'(done), 0);
    end
    @(negedge clk);
    check("t_done", int'(done), 1);
    check("t_ready", int'(din_ready), 1);
    check("t_gap_valid", int'(sout_valid), 0);
    @(posedge clk); #1;

    // ce low holds the first bit.
    send(4'b1100);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_sout", int'(sout), 1);
      check("hold_done", int'(done), 0);
      check("hold_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    wait_done();

    // Reset in the middle of a word.
    send(4'b0110);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mrst_sout", int'(sout), 1);
    check("mrst_busy", int'(busy), 0);
    check("mrst_ready", int'(din_ready), 1);
    check("mrst_valid", int'(sout_valid), 0);
    check("mrst_done", int'(done), 0);
    exp_q.delete();
    words_exp--;
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'b1001);
    wait_done();

    // Input churn while busy must not disturb the word in flight.
    send(4'b0101);
    din = 4'b1111;
    din_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("busy_ready", int'(din_ready), 0);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    wait_done();

    // Parity words (trailer only expected with the macro).
    send(4'b0111);
    wait_done();
    send(4'b0011);
    wait_done();

    // Back-to-back with din_valid held high.
    din = 4'b1010;
    din_valid = 1'b1;
    push_word(4'b1010);
    push_word(4'b0101);
    @(posedge clk); #1;
    din = 4'b0101;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("b2b_valid", int'(sout_valid), 1);
    end
    @(negedge clk);
    check("b2b_gap", int'(sout_valid), 0);
    check("b2b_ready", int'(din_ready), 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    check("b2b_second", int'(sout_valid), 1);
    wait_done();

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, words_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg4_piso_tx.md
REG4_PISO_TX -- requirements
Module: reg4_piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the parallel word width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 1'b1, meaning the sout value while no word is in flight.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ce, input, 1 bit: shift enable that qualifies bit advance only.
REQ-006 The block SHALL have port din, input, WIDTH bits: the parallel word to transmit.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for transmission.
REQ-008 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-009 The block SHALL have port sout, output, 1 bit: serial data, MSB first.
REQ-010 The block SHALL have port sout_valid, output, 1 bit: sout carries a data or parity bit.
REQ-011 The block SHALL have port busy, output, 1 bit: a word is in flight (state is not IDLE).
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that a word has completed.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only when the macro in REQ-029 is defined.
REQ-014 In IDLE: din_ready=1, sout=IDLE_LEVEL, sout_valid=0, busy=0.
REQ-015 A word SHALL be accepted on a rising edge with din_valid=1 and din_ready=1, independent of ce: din is captured into the shift register, the bit counter is set to WIDTH-1, and the state goes to SHIFT.
REQ-016 In SHIFT and PARITY: din_ready=0, busy=1, sout_valid=1; din_valid SHALL be ignored and din SHALL NOT be sampled.
REQ-017 In SHIFT, sout SHALL equal the shift register MSB; the first bit appears in the cycle after acceptance.
REQ-018 On an edge in SHIFT with ce=1 and counter>0, the register SHALL shift left by one and the counter SHALL decrement.
REQ-019 On an edge in SHIFT with ce=1 and counter=0: the state SHALL go to PARITY if enabled, otherwise to IDLE with done=1 in the following cycle.
REQ-020 When ce=0 in SHIFT or PARITY, the state, shift register, counter and sout SHALL hold.
REQ-021 Each data bit SHALL therefore occupy sout for exactly one ce-qualified cycle; with ce tied high, a word takes WIDTH cycles.
REQ-022 done SHALL be a registered output, high for exactly one clk cycle after the word's final bit edge, and 0 otherwise.
REQ-023 After completion the block SHALL spend at least one cycle in IDLE before accepting the next word; with din_valid held high, sout_valid has one 0 cycle between words.
REQ-024 The counter SHALL never wrap; once it reaches 0, the next ce-qualified edge exits SHIFT.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, shift register=0, counter=0, done=0 and sout=IDLE_LEVEL.
REQ-026 During reset, outputs SHALL be din_ready=1, sout_valid=0 and busy=0.
REQ-027 rst asserted mid-word SHALL discard the in-flight word with no done pulse.
REQ-028 After rst deasserts, the first rising edge with din_valid=1 SHALL be accepted.

Configuration
REQ-029 With macro REG4_TX_PARITY_EN defined, the block SHALL compute even parity (XOR of the captured din) at acceptance and send it in PARITY as one extra ce-qualified bit; done follows that bit, for WIDTH+1 cycles per word.
REQ-030 With REG4_TX_PARITY_EN undefined, the block SHALL omit the PARITY state and parity logic; done follows the LSB, for WIDTH cycles per word.

Verification
REQ-031 Macro off, WIDTH=4, ce=1: load 4'b1011 -> sout 1,0,1,1 with sout_valid=1 on cycles 1-4 after acceptance, done=1 on cycle 5, din_ready=1 on cycle 5.
REQ-032 Load 4'b1100, ce=0 for 3 cycles after the first bit -> sout holds 1 for 4 cycles, then 1,0,0 follow; done only after the 4th qualified bit.
REQ-033 Load 4'b0110, assert rst during bit 2 -> sout=1 and busy=0 immediately, no done, next word 4'b1001 transmits correctly.
REQ-034 While busy, toggle din/din_valid with 4'b1111 -> din_ready=0 and transmitted bits unchanged from the accepted word 4'b0101.
REQ-035 Macro on: load 4'b0111 -> sout 0,1,1,1 then parity 1, done on cycle 6; load 4'b0011 -> parity 0.
REQ-036 din_valid held high with words 4'b1010 and 4'b0101 -> both transmitted in order, one sout_valid=0 cycle between them.
